// File: rtl/const_div_pkg.sv
// Shared types and elaboration-time helpers for the constant-divisor sequential divider.
package const_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int clog2_ceil(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < v) begin
        r = i + 1;
      end
    end
    return r;
  endfunction

  function automatic int div_steps(input int width, input int chunk);
    return (width + chunk - 1) / chunk;
  endfunction

endpackage

// File: rtl/const_div_step.sv
// One digit-recurrence step: (rem, chunk) -> (digit, rem_nxt) via a table elaborated from DIVISOR.
module const_div_step
  import const_div_pkg::*;
#(
  parameter int DIVISOR = 5,
  parameter int CHUNK   = 3,
  parameter int RW      = clog2_ceil(DIVISOR)
) (
  input  logic [RW-1:0]    rem,
  input  logic [CHUNK-1:0] chunk,
  output logic [CHUNK-1:0] digit,
  output logic [RW-1:0]    rem_nxt
);

  localparam int EW = CHUNK + RW;
  localparam int NT = 1 << EW;

  // Rows with rem >= DIVISOR are unreachable and left as zero.
  function automatic logic [NT*EW-1:0] build_table();
    logic [NT*EW-1:0] tbl;
    int r;
    int c;
    int t;
    tbl = '0;
    for (int i = 0; i < NT; i++) begin
      r = i >> CHUNK;
      c = i % (1 << CHUNK);
      t = r * (1 << CHUNK) + c;
      if (r < DIVISOR) begin
        tbl[i*EW +: EW] = {CHUNK'(t / DIVISOR), RW'(t % DIVISOR)};
      end else begin
        tbl[i*EW +: EW] = '0;
      end
    end
    return tbl;
  endfunction

  localparam logic [NT*EW-1:0] TABLE = build_table();

  logic [EW-1:0] rows_s [NT];

  for (genvar g = 0; g < NT; g++) begin : g_row
    assign rows_s[g] = TABLE[g*EW +: EW];
  end

  assign {digit, rem_nxt} = rows_s[{rem, chunk}];

endmodule

// File: rtl/const_div_seq.sv
// Handshaked multi-cycle unsigned divider by a constant; CHUNK dividend bits per clock, MSB first.
module const_div_seq
  import const_div_pkg::*;
#(
  parameter int WIDTH   = 64,
  parameter int DIVISOR = 5,
  parameter int CHUNK   = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_x,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_q,
  output logic [$clog2(DIVISOR)-1:0] out_r,
  output logic                       out_exact,
  output logic                       busy
);

  localparam int RW    = $clog2(DIVISOR);
  localparam int STEPS = div_steps(WIDTH, CHUNK);
  localparam int PW    = STEPS * CHUNK;
  localparam int CW    = clog2_ceil(STEPS + 1);

  state_t           state_r;
  state_t           state_nxt_s;
  logic [PW-1:0]    x_r;
  logic [PW-1:0]    q_r;
  logic [PW-1:0]    q_shift_s;
  logic [RW-1:0]    rem_r;
  logic [RW-1:0]    rem_nxt_s;
  logic [CHUNK-1:0] digit_s;
  logic [CW-1:0]    cnt_r;
  logic             last_s;
  logic [WIDTH-1:0] out_q_r;
  logic [RW-1:0]    out_r_r;
  logic             out_exact_r;

  const_div_step #(
    .DIVISOR (DIVISOR),
    .CHUNK   (CHUNK),
    .RW      (RW)
  ) u_step (
    .rem     (rem_r),
    .chunk   (x_r[PW-1 -: CHUNK]),
    .digit   (digit_s),
    .rem_nxt (rem_nxt_s)
  );

  assign q_shift_s = (q_r << CHUNK) | PW'(digit_s);
  assign last_s    = (cnt_r == CW'(STEPS - 1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; flush overrides any transition including an accept.
  always_comb begin
    state_nxt_s = state_r;
    if (flush) begin
      state_nxt_s = IDLE;
    end else begin
      case (state_r)
        IDLE:    state_nxt_s = in_valid ? RUN : IDLE;
        RUN:     state_nxt_s = last_s ? DONE : RUN;
        DONE:    state_nxt_s = out_ready ? IDLE : DONE;
        default: state_nxt_s = IDLE;
      endcase
    end
  end

  // Handshake and status decode.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state_r)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      RUN:  out_valid = 1'b0;
      DONE: out_valid = 1'b1;
      default: begin
        in_ready = 1'b0;
        busy     = 1'b1;
      end
    endcase
  end

  // Datapath: load on accept, shift one chunk per RUN edge, capture result on the final step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_r         <= '0;
      q_r         <= '0;
      rem_r       <= '0;
      cnt_r       <= '0;
      out_q_r     <= '0;
      out_r_r     <= '0;
      out_exact_r <= 1'b1;
    end else if (state_r == IDLE && state_nxt_s == RUN) begin
      x_r   <= PW'(in_x);
      q_r   <= '0;
      rem_r <= '0;
      cnt_r <= '0;
    end else if (state_r == RUN && !flush) begin
      x_r   <= x_r << CHUNK;
      q_r   <= q_shift_s;
      rem_r <= rem_nxt_s;
      cnt_r <= cnt_r + CW'(1);
      if (last_s) begin
        // Quotient bits above WIDTH are always zero and are dropped here.
        out_q_r     <= q_shift_s[WIDTH-1:0];
        out_r_r     <= rem_nxt_s;
        out_exact_r <= (rem_nxt_s == {RW{1'b0}});
      end
    end
  end

  assign out_q     = out_q_r;
  assign out_r     = out_r_r;
  assign out_exact = out_exact_r;

endmodule

// File: tb/tb_const_div_seq.sv
// Self-checking bench for const_div_seq: three parameter sets behind one shared handshake driver.
module tb_const_div_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [63:0] in_x;
  int          sel;

  int checks   = 0;
  int failures = 0;
  int viol     = 0;

  logic        ir_a, ov_a, ex_a, bz_a;
  logic [63:0] oq_a;
  logic [2:0]  or_a;
  logic        ir_b, ov_b, ex_b, bz_b;
  logic [31:0] oq_b;
  logic [2:0]  or_b;
  logic        ir_c, ov_c, ex_c, bz_c;
  logic [32:0] oq_c;
  logic [2:0]  or_c;

  logic        ir, ov, ex, bz;
  logic [63:0] oq;
  logic [7:0]  orm;

  int          steps_of [3] = '{22, 8, 7};
  int          width_of [3] = '{64, 32, 33};
  logic [63:0] div_of   [3] = '{64'd5, 64'd7, 64'd8};

  always #5 clk = ~clk;

  const_div_seq #(.WIDTH(64), .DIVISOR(5), .CHUNK(3)) u_a (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid && sel == 0), .in_ready(ir_a), .in_x(in_x),
    .out_valid(ov_a), .out_ready(out_ready && sel == 0),
    .out_q(oq_a), .out_r(or_a), .out_exact(ex_a), .busy(bz_a)
  );

  const_div_seq #(.WIDTH(32), .DIVISOR(7), .CHUNK(4)) u_b (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid && sel == 1), .in_ready(ir_b), .in_x(in_x[31:0]),
    .out_valid(ov_b), .out_ready(out_ready && sel == 1),
    .out_q(oq_b), .out_r(or_b), .out_exact(ex_b), .busy(bz_b)
  );

  const_div_seq #(.WIDTH(33), .DIVISOR(8), .CHUNK(5)) u_c (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid && sel == 2), .in_ready(ir_c), .in_x(in_x[32:0]),
    .out_valid(ov_c), .out_ready(out_ready && sel == 2),
    .out_q(oq_c), .out_r(or_c), .out_exact(ex_c), .busy(bz_c)
  );

  always_comb begin
    ir = ir_a; ov = ov_a; ex = ex_a; bz = bz_a; oq = oq_a; orm = {5'd0, or_a};
    case (sel)
      1: begin ir = ir_b; ov = ov_b; ex = ex_b; bz = bz_b; oq = {32'd0, oq_b}; orm = {5'd0, or_b}; end
      2: begin ir = ir_c; ov = ov_c; ex = ex_c; bz = bz_c; oq = {31'd0, oq_c}; orm = {5'd0, or_c}; end
      default: ;
    endcase
  end

  // A unit reporting busy must never also take a dividend.
  always @(posedge clk) begin
    if (rst_n && in_valid && ir && bz) viol++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // One full transaction; junk drives random in_valid during RUN, gap holds out_ready low.
  task automatic do_op(input int s, input logic [63:0] x, input bit junk, input int gap,
                       output logic [63:0] q, output logic [7:0] r, output logic e, output int lat);
    int n;
    @(negedge clk);
    sel = s;
    n = 0;
    while (!ir && n < 50) begin @(negedge clk); n++; end
    chk("in_ready_wait", {63'd0, ir}, 64'd1);
    in_x = x;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!ov && lat < 200) begin
      if (junk) begin
        in_valid = 1'($urandom % 2);
        in_x = {$urandom, $urandom};
      end
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    q = oq; r = orm; e = ex;
    repeat (gap) @(posedge clk);
    #1;
    chk("hold_q", oq, q);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic watch_idle(input string name, input int cycles);
    logic seen;
    seen = 1'b0;
    repeat (cycles) begin
      @(posedge clk); #1;
      if (ov) seen = 1'b1;
    end
    chk(name, {63'd0, seen}, 64'd0);
  endtask

  typedef struct {
    int          s;
    logic [63:0] x;
    logic [63:0] q;
    logic [7:0]  r;
    logic        e;
  } vec_t;

  vec_t vecs [9];

  initial begin
    logic [63:0] q, x, xm, eq;
    logic [7:0]  r;
    logic        e;
    int          lat;

    vecs[0] = '{0, 64'd0, 64'd0, 8'd0, 1'b1};
    vecs[1] = '{0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3689348814741910323, 8'd0, 1'b1};
    vecs[2] = '{0, 64'd12347, 64'd2469, 8'd2, 1'b0};
    vecs[3] = '{0, 64'd4, 64'd0, 8'd4, 1'b0};
    vecs[4] = '{1, 64'd100, 64'd14, 8'd2, 1'b0};
    vecs[5] = '{1, 64'd6, 64'd0, 8'd6, 1'b0};
    vecs[6] = '{2, 64'h1_FFFF_FFFF, 64'd1073741823, 8'd7, 1'b0};
    vecs[7] = '{2, 64'd8, 64'd1, 8'd0, 1'b1};
    vecs[8] = '{0, 64'd99, 64'd19, 8'd4, 1'b0};

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_x = '0; sel = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", {63'd0, ov}, 64'd0);
    chk("rst_busy", {63'd0, bz}, 64'd0);
    chk("rst_out_q", oq, 64'd0);
    chk("rst_out_r", {56'd0, orm}, 64'd0);
    chk("rst_exact", {63'd0, ex}, 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", {63'd0, ir}, 64'd1);

    foreach (vecs[i]) begin
      do_op(vecs[i].s, vecs[i].x, 1'b0, 1, q, r, e, lat);
      chk("vec_latency", lat, steps_of[vecs[i].s]);
      chk("vec_q", q, vecs[i].q);
      chk("vec_r", {56'd0, r}, {56'd0, vecs[i].r});
      chk("vec_exact", {63'd0, e}, {63'd0, vecs[i].e});
    end

    // Backpressure: result held five cycles, taken on the sixth.
    @(negedge clk);
    sel = 0; in_x = 64'd12345; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!ov && lat < 200) begin @(posedge clk); #1; lat++; end
    chk("bp_latency", lat, 22);
    for (int k = 0; k < 5; k++) begin
      chk("bp_q", oq, 64'd2469);
      chk("bp_r", {56'd0, orm}, 64'd0);
      chk("bp_in_ready", {63'd0, ir}, 64'd0);
      chk("bp_valid", {63'd0, ov}, 64'd1);
      @(posedge clk); #1;
    end
    chk("bp_exact", {63'd0, ex}, 64'd1);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_in_ready_after", {63'd0, ir}, 64'd1);
    chk("bp_valid_after", {63'd0, ov}, 64'd0);

    // Asynchronous reset in the middle of a run.
    @(negedge clk);
    in_x = 64'd12347; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", {63'd0, bz}, 64'd0);
    chk("mid_rst_valid", {63'd0, ov}, 64'd0);
    chk("mid_rst_q", oq, 64'd0);
    chk("mid_rst_exact", {63'd0, ex}, 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    watch_idle("mid_rst_no_result", 30);
    do_op(0, 64'd99, 1'b0, 0, q, r, e, lat);
    chk("after_rst_q", q, 64'd19);
    chk("after_rst_r", {56'd0, r}, 64'd4);

    // Synchronous flush in the middle of a run.
    @(negedge clk);
    in_x = 64'd12347; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_busy", {63'd0, bz}, 64'd0);
    chk("flush_valid", {63'd0, ov}, 64'd0);
    watch_idle("flush_no_result", 30);
    do_op(0, 64'd99, 1'b0, 0, q, r, e, lat);
    chk("after_flush_q", q, 64'd19);
    chk("after_flush_r", {56'd0, r}, 64'd4);

    // Flush beats a simultaneous accept.
    @(negedge clk);
    in_x = 64'd5; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    chk("flush_vs_accept", {63'd0, bz}, 64'd0);

    // Randomised dividends against plain-arithmetic reference.
    for (int s = 0; s < 3; s++) begin
      for (int n = 0; n < ((s == 0) ? 1000 : 1200); n++) begin
        x = {$urandom, $urandom};
        if (n % 8 == 0) x = x >> $urandom_range(0, 63);
        xm = (width_of[s] == 64) ? x : (x & ((64'd1 << width_of[s]) - 64'd1));
        eq = xm / div_of[s];
        repeat ($urandom_range(0, 2)) @(negedge clk);
        do_op(s, x, 1'b1, $urandom_range(0, 3), q, r, e, lat);
        chk("rand_latency", lat, steps_of[s]);
        chk("rand_q", q, eq);
        chk("rand_r", {56'd0, r}, xm % div_of[s]);
        chk("rand_exact", {63'd0, e}, {63'd0, (xm % div_of[s]) == 64'd0});
      end
    end

    chk("no_accept_outside_idle", viol, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
